// File: rtl/retry_remote_sm.sv
// Remote retry responder: answers RETRY.Req with a RETRY.Ack, then replays LLRB entries Eseq..WrPtr-1.
// A new Req in any state relatches its fields, snapshots the LLRB and restarts the Ack.
module retry_remote_sm #(
  parameter int PTR_W = 8,
  parameter int CNT_W = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_rx_retry_req_valid,
  input  logic [PTR_W-1:0] i_rx_retry_req_eseq,
  input  logic [CNT_W-1:0] i_rx_retry_req_num_retry,
  input  logic [CNT_W-1:0] i_rx_retry_req_num_phy_reinit,
  input  logic [PTR_W-1:0] i_llrb_wr_ptr,
  input  logic [PTR_W:0]   i_llrb_num_valid,
  output logic             o_tx_retry_ack_valid,
  input  logic             i_tx_retry_ack_ready,
  output logic [PTR_W-1:0] o_tx_retry_ack_wr_ptr,
  output logic [CNT_W-1:0] o_tx_retry_ack_num_retry,
  output logic [CNT_W-1:0] o_tx_retry_ack_num_phy_reinit,
  output logic             o_tx_retry_ack_empty,
  output logic             o_replay_valid,
  input  logic             i_replay_ready,
  output logic [PTR_W-1:0] o_replay_rd_ptr,
  output logic             o_replay_done,
  output logic             o_retry_error,
  output logic             o_rrsm_busy,
  output logic [1:0]       o_state
);

  typedef enum logic [1:0] {
    NORMAL = 2'd0,
    LLRACK = 2'd1,
    REPLAY = 2'd2
  } state_t;

  localparam logic [PTR_W:0] REM_LAST = {{PTR_W{1'b0}}, 1'b1};

  state_t           state_q;
  logic [PTR_W-1:0] eseq_q;
  logic [PTR_W-1:0] wr_snap_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   cnt_q;
  logic [PTR_W:0]   rem_q;
  logic [CNT_W-1:0] num_retry_q;
  logic [CNT_W-1:0] num_phy_q;
  logic             err_q;
  logic             empty_q;
  logic             ack_vld_q;
  logic             rpl_vld_q;
  logic             done_q;
  logic             rerr_q;

  // Distance from Eseq to the write pointer wraps naturally in PTR_W bits.
  logic [PTR_W:0] req_cnt_d;
  logic           req_err_d;
  assign req_cnt_d = {1'b0, i_llrb_wr_ptr - i_rx_retry_req_eseq};
  assign req_err_d = (req_cnt_d > i_llrb_num_valid);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= NORMAL;
      eseq_q      <= '0;
      wr_snap_q   <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      rem_q       <= '0;
      num_retry_q <= '0;
      num_phy_q   <= '0;
      err_q       <= 1'b0;
      empty_q     <= 1'b0;
      ack_vld_q   <= 1'b0;
      rpl_vld_q   <= 1'b0;
      done_q      <= 1'b0;
      rerr_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      rerr_q <= 1'b0;
      if (i_rx_retry_req_valid) begin
        // A Req preempts everything: an in-flight Ack or replay is abandoned.
        eseq_q      <= i_rx_retry_req_eseq;
        num_retry_q <= i_rx_retry_req_num_retry;
        num_phy_q   <= i_rx_retry_req_num_phy_reinit;
        wr_snap_q   <= i_llrb_wr_ptr;
        cnt_q       <= req_cnt_d;
        err_q       <= req_err_d;
        empty_q     <= (i_llrb_num_valid == '0);
        rerr_q      <= req_err_d;
        state_q     <= LLRACK;
        ack_vld_q   <= 1'b1;
        rpl_vld_q   <= 1'b0;
      end else begin
        case (state_q)
          LLRACK: begin
            if (i_tx_retry_ack_ready) begin
              ack_vld_q <= 1'b0;
              if (cnt_q == '0 || err_q) begin
                state_q <= NORMAL;
                done_q  <= 1'b1;
              end else begin
                state_q   <= REPLAY;
                rpl_vld_q <= 1'b1;
                rd_ptr_q  <= eseq_q;
                rem_q     <= cnt_q;
              end
            end
          end
          REPLAY: begin
            if (i_replay_ready) begin
              rd_ptr_q <= rd_ptr_q + 1'b1;
              rem_q    <= rem_q - 1'b1;
              if (rem_q == REM_LAST) begin
                state_q   <= NORMAL;
                rpl_vld_q <= 1'b0;
                done_q    <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign o_tx_retry_ack_valid          = ack_vld_q;
  assign o_tx_retry_ack_wr_ptr         = wr_snap_q;
  assign o_tx_retry_ack_num_retry      = num_retry_q;
  assign o_tx_retry_ack_num_phy_reinit = num_phy_q;
  assign o_tx_retry_ack_empty          = empty_q;
  assign o_replay_valid                = rpl_vld_q;
  assign o_replay_rd_ptr               = rd_ptr_q;
  assign o_replay_done                 = done_q;
  assign o_retry_error                 = rerr_q;
  assign o_rrsm_busy                   = (state_q != NORMAL);
  assign o_state                       = state_q;

endmodule

// File: tb/tb_retry_remote_sm.sv
// Bench for retry_remote_sm: queue-based reference model compared every cycle, plus directed literal checks.
module tb_retry_remote_sm;
  localparam int PTR_W = 8;
  localparam int CNT_W = 5;
  localparam int DEPTH = 1 << PTR_W;

  logic i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic             i_rst_n;
  logic             i_rx_retry_req_valid;
  logic [PTR_W-1:0] i_rx_retry_req_eseq;
  logic [CNT_W-1:0] i_rx_retry_req_num_retry;
  logic [CNT_W-1:0] i_rx_retry_req_num_phy_reinit;
  logic [PTR_W-1:0] i_llrb_wr_ptr;
  logic [PTR_W:0]   i_llrb_num_valid;
  logic             i_tx_retry_ack_ready;
  logic             i_replay_ready;
  logic             o_tx_retry_ack_valid;
  logic [PTR_W-1:0] o_tx_retry_ack_wr_ptr;
  logic [CNT_W-1:0] o_tx_retry_ack_num_retry;
  logic [CNT_W-1:0] o_tx_retry_ack_num_phy_reinit;
  logic             o_tx_retry_ack_empty;
  logic             o_replay_valid;
  logic [PTR_W-1:0] o_replay_rd_ptr;
  logic             o_replay_done;
  logic             o_retry_error;
  logic             o_rrsm_busy;
  logic [1:0]       o_state;

  retry_remote_sm #(.PTR_W(PTR_W), .CNT_W(CNT_W)) dut (
    .i_clk                         (i_clk),
    .i_rst_n                       (i_rst_n),
    .i_rx_retry_req_valid          (i_rx_retry_req_valid),
    .i_rx_retry_req_eseq           (i_rx_retry_req_eseq),
    .i_rx_retry_req_num_retry      (i_rx_retry_req_num_retry),
    .i_rx_retry_req_num_phy_reinit (i_rx_retry_req_num_phy_reinit),
    .i_llrb_wr_ptr                 (i_llrb_wr_ptr),
    .i_llrb_num_valid              (i_llrb_num_valid),
    .o_tx_retry_ack_valid          (o_tx_retry_ack_valid),
    .i_tx_retry_ack_ready          (i_tx_retry_ack_ready),
    .o_tx_retry_ack_wr_ptr         (o_tx_retry_ack_wr_ptr),
    .o_tx_retry_ack_num_retry      (o_tx_retry_ack_num_retry),
    .o_tx_retry_ack_num_phy_reinit (o_tx_retry_ack_num_phy_reinit),
    .o_tx_retry_ack_empty          (o_tx_retry_ack_empty),
    .o_replay_valid                (o_replay_valid),
    .i_replay_ready                (i_replay_ready),
    .o_replay_rd_ptr               (o_replay_rd_ptr),
    .o_replay_done                 (o_replay_done),
    .o_retry_error                 (o_retry_error),
    .o_rrsm_busy                   (o_rrsm_busy),
    .o_state                       (o_state)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a pending-Ack flag plus a queue of LLRB indices still to be replayed.
  bit         m_ack = 1'b0, m_done = 1'b0, m_err = 1'b0, m_empty = 1'b0, m_bad = 1'b0;
  logic [7:0] m_wr = '0, m_eseq = '0;
  logic [4:0] m_nr = '0, m_npr = '0;
  int         m_cnt = 0;
  int         m_q[$];

  // Logs of what the DUT actually did, checked against hand-computed literals.
  logic [7:0] beats[$];
  logic [4:0] ack_nr[$];
  logic [7:0] ack_wr[$];
  bit         ack_empty[$];
  int         done_cnt = 0;
  int         err_cnt  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp_v, $time);
    end
  endtask

  task automatic model_step();
    bit nd = 1'b0;
    bit ne = 1'b0;
    if (!i_rst_n) begin
      m_ack = 0; m_done = 0; m_err = 0; m_empty = 0; m_bad = 0;
      m_wr = '0; m_eseq = '0; m_nr = '0; m_npr = '0; m_cnt = 0;
      m_q.delete();
      return;
    end
    if (i_rx_retry_req_valid) begin
      m_q.delete();
      m_ack   = 1'b1;
      m_eseq  = i_rx_retry_req_eseq;
      m_nr    = i_rx_retry_req_num_retry;
      m_npr   = i_rx_retry_req_num_phy_reinit;
      m_wr    = i_llrb_wr_ptr;
      m_cnt   = (int'(i_llrb_wr_ptr) - int'(i_rx_retry_req_eseq) + DEPTH) % DEPTH;
      m_bad   = (m_cnt > int'(i_llrb_num_valid));
      m_empty = (i_llrb_num_valid == 0);
      ne      = m_bad;
    end else if (m_ack) begin
      if (i_tx_retry_ack_ready) begin
        m_ack = 1'b0;
        if (m_cnt == 0 || m_bad) nd = 1'b1;
        else for (int i = 0; i < m_cnt; i++) m_q.push_back((int'(m_eseq) + i) % DEPTH);
      end
    end else if (m_q.size() > 0 && i_replay_ready) begin
      void'(m_q.pop_front());
      if (m_q.size() == 0) nd = 1'b1;
    end
    m_done = nd;
    m_err  = ne;
  endtask

  initial forever begin
    @(posedge i_clk or negedge i_rst_n);
    model_step();
  end

  // Per-cycle compare and activity logging, away from the active edge.
  initial forever begin
    int exp_state;
    @(negedge i_clk);
    exp_state = m_ack ? 1 : ((m_q.size() > 0) ? 2 : 0);
    chk("ack_valid",   o_tx_retry_ack_valid, m_ack);
    chk("ack_wr_ptr",  o_tx_retry_ack_wr_ptr, m_wr);
    chk("ack_nr",      o_tx_retry_ack_num_retry, m_nr);
    chk("ack_npr",     o_tx_retry_ack_num_phy_reinit, m_npr);
    chk("ack_empty",   o_tx_retry_ack_empty, m_empty);
    chk("replay_vld",  o_replay_valid, (m_q.size() > 0));
    chk("done",        o_replay_done, m_done);
    chk("retry_error", o_retry_error, m_err);
    chk("busy",        o_rrsm_busy, (exp_state != 0));
    chk("state",       o_state, exp_state);
    if (m_q.size() > 0) chk("rd_ptr", o_replay_rd_ptr, m_q[0]);
    if (i_rst_n) begin
      if (o_replay_valid && i_replay_ready) beats.push_back(o_replay_rd_ptr);
      if (o_tx_retry_ack_valid && i_tx_retry_ack_ready) begin
        ack_nr.push_back(o_tx_retry_ack_num_retry);
        ack_wr.push_back(o_tx_retry_ack_wr_ptr);
        ack_empty.push_back(o_tx_retry_ack_empty);
      end
      if (o_replay_done) done_cnt++;
      if (o_retry_error) err_cnt++;
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_logs();
    beats.delete(); ack_nr.delete(); ack_wr.delete(); ack_empty.delete();
    done_cnt = 0;
    err_cnt  = 0;
  endtask

  // One-cycle Req; the LLRB inputs are scrambled afterwards since only the snapshot may matter.
  task automatic send_req(input logic [7:0] eseq, input logic [4:0] nr, input logic [4:0] npr,
                          input logic [7:0] wr, input logic [8:0] nv);
    i_rx_retry_req_valid          = 1'b1;
    i_rx_retry_req_eseq           = eseq;
    i_rx_retry_req_num_retry      = nr;
    i_rx_retry_req_num_phy_reinit = npr;
    i_llrb_wr_ptr                 = wr;
    i_llrb_num_valid              = nv;
    tick();
    i_rx_retry_req_valid = 1'b0;
    i_llrb_wr_ptr        = 8'($urandom);
    i_llrb_num_valid     = 9'($urandom_range(0, 255));
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (o_rrsm_busy && n < 600) begin
      tick();
      n++;
    end
    if (o_rrsm_busy) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: busy still 1 after %0d cycles, expected 0", nm, n);
    end
    tick();
    tick();
  endtask

  task automatic chk_beats(input string nm, input int offset, input int first, input int n);
    for (int i = 0; i < n; i++) begin
      if (offset + i < beats.size()) chk(nm, beats[offset + i], (first + i) % DEPTH);
      else chk(nm, 32'hFFFF_FFFF, (first + i) % DEPTH);
    end
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_ack_vld"},  o_tx_retry_ack_valid, 0);
    chk({nm, "_ack_wr"},   o_tx_retry_ack_wr_ptr, 0);
    chk({nm, "_ack_nr"},   o_tx_retry_ack_num_retry, 0);
    chk({nm, "_ack_npr"},  o_tx_retry_ack_num_phy_reinit, 0);
    chk({nm, "_ack_emp"},  o_tx_retry_ack_empty, 0);
    chk({nm, "_rpl_vld"},  o_replay_valid, 0);
    chk({nm, "_rd_ptr"},   o_replay_rd_ptr, 0);
    chk({nm, "_done"},     o_replay_done, 0);
    chk({nm, "_err"},      o_retry_error, 0);
    chk({nm, "_busy"},     o_rrsm_busy, 0);
    chk({nm, "_state"},    o_state, 0);
  endtask

  initial begin
    i_rst_n                       = 1'b0;
    i_rx_retry_req_valid          = 1'b0;
    i_rx_retry_req_eseq           = '0;
    i_rx_retry_req_num_retry      = '0;
    i_rx_retry_req_num_phy_reinit = '0;
    i_llrb_wr_ptr                 = '0;
    i_llrb_num_valid              = '0;
    i_tx_retry_ack_ready          = 1'b0;
    i_replay_ready                = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    i_rst_n = 1'b1;
    tick();

    // Basic replay 0x10..0x13.
    clear_logs();
    i_tx_retry_ack_ready = 1'b1;
    i_replay_ready       = 1'b1;
    send_req(8'h10, 5'd1, 5'd3, 8'h14, 9'd8);
    chk("s1_ack_n1", o_tx_retry_ack_valid, 1);
    wait_idle("s1");
    chk("s1_nbeats", beats.size(), 4);
    chk_beats("s1_beat", 0, 'h10, 4);
    chk("s1_done", done_cnt, 1);
    chk("s1_nacks", ack_wr.size(), 1);
    if (ack_wr.size() > 0) begin
      chk("s1_ack_wr", ack_wr[0], 8'h14);
      chk("s1_ack_empty", ack_empty[0], 0);
    end

    // Wrap-around with a 3-cycle replay stall.
    clear_logs();
    send_req(8'hFE, 5'd2, 5'd0, 8'h02, 9'd10);
    tick();
    tick();
    i_replay_ready = 1'b0;
    repeat (3) tick();
    chk("s2_hold", o_replay_rd_ptr, 8'hFF);
    i_replay_ready = 1'b1;
    wait_idle("s2");
    chk("s2_nbeats", beats.size(), 4);
    chk_beats("s2_beat", 0, 'hFE, 4);
    chk("s2_done", done_cnt, 1);

    // Empty buffer: Ack only.
    clear_logs();
    send_req(8'h30, 5'd0, 5'd1, 8'h30, 9'd0);
    wait_idle("s3");
    chk("s3_nbeats", beats.size(), 0);
    chk("s3_done", done_cnt, 1);
    if (ack_empty.size() > 0) chk("s3_empty", ack_empty[0], 1);
    else chk("s3_nacks", ack_empty.size(), 1);

    // Eseq outside the window: error pulse, Ack, no replay.
    clear_logs();
    send_req(8'h00, 5'd4, 5'd2, 8'h20, 9'd4);
    chk("s4_err_n1", o_retry_error, 1);
    wait_idle("s4");
    chk("s4_errs", err_cnt, 1);
    chk("s4_nbeats", beats.size(), 0);
    chk("s4_nacks", ack_wr.size(), 1);
    chk("s4_done", done_cnt, 1);

    // Ack stalled, then relatched by a second Req.
    clear_logs();
    i_tx_retry_ack_ready = 1'b0;
    send_req(8'h40, 5'd1, 5'd0, 8'h42, 9'd5);
    repeat (5) tick();
    chk("s5_hold_vld", o_tx_retry_ack_valid, 1);
    chk("s5_hold_nr", o_tx_retry_ack_num_retry, 1);
    send_req(8'h40, 5'd2, 5'd0, 8'h41, 9'd2);
    chk("s5_relatch_vld", o_tx_retry_ack_valid, 1);
    chk("s5_relatch_nr", o_tx_retry_ack_num_retry, 2);
    i_tx_retry_ack_ready = 1'b1;
    wait_idle("s5a");
    chk("s5_nacks", ack_nr.size(), 1);
    chk("s5_nbeats", beats.size(), 1);
    chk_beats("s5_beat", 0, 'h40, 1);

    // Req coincident with the Ack handshake.
    clear_logs();
    i_tx_retry_ack_ready = 1'b0;
    send_req(8'h70, 5'd3, 5'd0, 8'h72, 9'd4);
    tick();
    tick();
    i_tx_retry_ack_ready = 1'b1;
    send_req(8'h80, 5'd4, 5'd0, 8'h83, 9'd3);
    wait_idle("s5b");
    chk("s5b_nacks", ack_nr.size(), 2);
    if (ack_nr.size() == 2) begin
      chk("s5b_ack0_nr", ack_nr[0], 3);
      chk("s5b_ack1_nr", ack_nr[1], 4);
    end
    chk("s5b_nbeats", beats.size(), 3);
    chk_beats("s5b_beat", 0, 'h80, 3);
    chk("s5b_done", done_cnt, 1);

    // Req during beat 2 of a 6-beat replay.
    clear_logs();
    send_req(8'h50, 5'd1, 5'd2, 8'h56, 9'd6);
    tick();
    tick();
    send_req(8'h60, 5'd5, 5'd6, 8'h62, 9'd3);
    chk("s6_abort_rpl", o_replay_valid, 0);
    chk("s6_abort_ack", o_tx_retry_ack_valid, 1);
    wait_idle("s6");
    chk("s6_nbeats", beats.size(), 4);
    chk_beats("s6_old", 0, 'h50, 2);
    chk_beats("s6_new", 2, 'h60, 2);
    chk("s6_done", done_cnt, 1);
    chk("s6_nacks", ack_nr.size(), 2);

    // Randomized traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      i_tx_retry_ack_ready          = ($urandom_range(0, 3) != 0);
      i_replay_ready                = ($urandom_range(0, 3) != 0);
      i_llrb_wr_ptr                 = 8'($urandom);
      i_llrb_num_valid              = 9'($urandom_range(0, 20));
      i_rx_retry_req_valid          = ($urandom_range(0, 11) == 0);
      i_rx_retry_req_eseq           = i_llrb_wr_ptr - 8'($urandom_range(0, 24));
      i_rx_retry_req_num_retry      = 5'($urandom);
      i_rx_retry_req_num_phy_reinit = 5'($urandom);
      tick();
    end
    i_rx_retry_req_valid = 1'b0;
    i_tx_retry_ack_ready = 1'b1;
    i_replay_ready       = 1'b1;
    wait_idle("rand");

    // Reset in the middle of a long replay.
    send_req(8'h00, 5'd7, 5'd7, 8'h40, 9'h080);
    repeat (4) tick();
    chk("s7_in_replay", o_state, 2);
    i_rst_n = 1'b0;
    #1;
    check_all_zero("s7_rst");
    tick();
    i_rst_n = 1'b1;
    tick();
    chk("s7_state", o_state, 0);
    chk("s7_busy", o_rrsm_busy, 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/retry_remote_sm.md
Name: retry_remote_sm

Overview:
- Remote Retry State Machine (RRSM) for the CXL link-layer retry path. It is the responder to the local retry machine's RETRY.Req/timeout flow.
- On each received RETRY.Req it latches the request fields, snapshots the Local Link Retry Buffer (LLRB) state, and issues a RETRY.Ack to the TX arbiter.
- After the Ack it replays LLRB entries from the requested expected sequence (Eseq) up to the write pointer, using a valid/ready handshake to the TX flit path.

Parameters:
- PTR_W, 8, LLRB pointer/sequence width; LLRB depth = 2^PTR_W, and all pointer arithmetic is modulo 2^PTR_W.
- CNT_W, 5, width of the NumRetry and NumPhyReinit fields.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_rx_retry_req_valid  in  1  one-cycle pulse: decoded RETRY.Req received
- i_rx_retry_req_eseq  in  PTR_W  Eseq carried by the Req
- i_rx_retry_req_num_retry  in  CNT_W  NumRetry carried by the Req
- i_rx_retry_req_num_phy_reinit  in  CNT_W  NumPhyReinit carried by the Req
- i_llrb_wr_ptr  in  PTR_W  current LLRB write pointer
- i_llrb_num_valid  in  PTR_W+1  number of valid (unacknowledged) LLRB entries
- o_tx_retry_ack_valid  out  1  RETRY.Ack request to the TX arbiter
- i_tx_retry_ack_ready  in  1  TX arbiter accepts the Ack
- o_tx_retry_ack_wr_ptr  out  PTR_W  Ack WrPtr field
- o_tx_retry_ack_num_retry  out  CNT_W  Ack NumRetry field (echo of the Req)
- o_tx_retry_ack_num_phy_reinit  out  CNT_W  Ack NumPhyReinit field (echo of the Req)
- o_tx_retry_ack_empty  out  1  Ack Empty bit
- o_replay_valid  out  1  replay read request
- i_replay_ready  in  1  replay beat accepted
- o_replay_rd_ptr  out  PTR_W  LLRB index being replayed
- o_replay_done  out  1  one-cycle pulse: retry sequence finished
- o_retry_error  out  1  one-cycle pulse: Eseq outside the valid LLRB window
- o_rrsm_busy  out  1  state != NORMAL
- o_state  out  2  0=NORMAL, 1=LLRACK, 2=REPLAY

Behaviour:
- Reset (async assert, sync deassert):
  - state=NORMAL.
  - All outputs 0.
  - Latched fields, rd_ptr and the remaining count are 0.
- Req sampling (in any state, cycle N):
  - Latch eseq, num_retry and num_phy_reinit.
  - Snapshot wr_snap=i_llrb_wr_ptr and nv_snap=i_llrb_num_valid.
  - Compute cnt=(wr_snap-eseq) mod 2^PTR_W, held in a PTR_W+1-bit register.
  - err=(cnt>nv_snap).
  - Go to LLRACK. o_tx_retry_ack_valid=1 from cycle N+1.
- Ack fields:
  - o_tx_retry_ack_wr_ptr=wr_snap.
  - o_tx_retry_ack_num_retry and o_tx_retry_ack_num_phy_reinit echo the latched Req values.
  - o_tx_retry_ack_empty=(nv_snap==0).
  - Fields are stable while valid=1 and ready=0.
- o_retry_error pulses in cycle N+1 when err=1.
- LLRACK: hold valid until ready. On handshake (cycle M):
  - If cnt==0 or err: go to NORMAL and pulse o_replay_done in M+1.
  - Else: go to REPLAY with rd_ptr=eseq and rem=cnt. o_replay_valid=1 from M+1.
- REPLAY:
  - o_replay_valid=1 and o_replay_rd_ptr=rd_ptr.
  - Each cycle with ready=1: rd_ptr=rd_ptr+1 (wraps 2^PTR_W-1 to 0), rem=rem-1.
  - Beat with rem==1 accepted: go to NORMAL, o_replay_valid=0, and o_replay_done pulses the next cycle.
- Simultaneous events:
  - Req in LLRACK with ready=0: relatch; the new fields appear in N+1, and valid stays high.
  - Req in LLRACK with ready=1 in the same cycle: the Ack completes with the old fields. Next state is LLRACK with the new fields. No done pulse and no replay for the old Req.
  - Req in REPLAY: the replay aborts (the beat accepted in the same cycle counts, then is discarded). o_replay_valid=0 in N+1, and the machine goes to LLRACK with the new fields. No done pulse.
- o_replay_valid and o_tx_retry_ack_valid are never high together.
- i_llrb_* changes after the snapshot are ignored until the next Req.

Test Plan:
- Reset mid-REPLAY (PTR_W=8): assert i_rst_n=0 -> all outputs 0 immediately; after release, state=NORMAL.
- Eseq=0x10, wr_ptr=0x14, num_valid=8, ready always 1 -> ack_valid in cycle N+1 with wr_ptr=0x14 and empty=0; replay beats 0x10..0x13 over 4 cycles; done pulses once.
- Wrap-around: Eseq=0xFE, wr_ptr=0x02, num_valid=10 -> 4 beats 0xFE, 0xFF, 0x00, 0x01. Insert i_replay_ready=0 for 3 cycles mid-replay -> rd_ptr holds and no beat is lost.
- Eseq==wr_ptr=0x30, num_valid=0 -> Ack with empty=1; no replay; done pulses 1 cycle after the handshake. Then Eseq=0x00, wr_ptr=0x20, num_valid=4 -> error pulse in N+1; Ack still sent; no replay.
- Ack ready held 0 for 5 cycles, then a second Req (num_retry 1->2) -> Ack fields switch to num_retry=2 while valid stays high. Second Req coincident with ready=1 -> first Ack accepted, then a second Ack is sent.
- Req during beat 2 of 6 of a replay -> o_replay_valid drops the next cycle; a new Ack is sent; no done pulse until the new sequence completes.
